// File: rtl/bcd_converter_seq_if.sv
// rtl/bcd_converter_seq_if.sv - request/result bundle for the sequential binary-to-BCD converter
interface bcd_converter_seq_if #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
);
   logic                  start;
   logic [WIDTH-1:0]      number_in;
   logic                  is_signed;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  negative;
   logic [DIGITS-1:0]     digit_valid;

   modport master (
      output start, number_in, is_signed,
      input  busy, done, bcd_out, negative, digit_valid
   );

   modport slave (
      input  start, number_in, is_signed,
      output busy, done, bcd_out, negative, digit_valid
   );
endinterface

// File: rtl/bcd_converter_seq.sv
// rtl/bcd_converter_seq.sv - iterative double-dabble converter, one bit per clock
// DIGITS must satisfy 10^DIGITS > 2^WIDTH-1 so the top digit never overflows.
module bcd_converter_seq #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic              clk,
   input  logic              reset,
   bcd_converter_seq_if.slave cnv
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;

   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  mag_q, mag_d;
   logic [BW-1:0]     work_q, work_d;
   logic              sign_q, sign_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [BW-1:0]     bcd_q, bcd_d;
   logic              neg_q, neg_d;
   logic [DIGITS-1:0] dv_q, dv_d;
   logic              done_q, done_d;

   logic [BW-1:0]       adj;
   logic [BW+WIDTH-1:0] shifted;
   logic [WIDTH-1:0]    neg_mag;
   logic [DIGITS-1:0]   mask;
   logic                seen;

   // Negation stays WIDTH bits wide, so the most negative input maps onto its own magnitude.
   assign neg_mag = ~cnv.number_in + {{(WIDTH-1){1'b0}}, 1'b1};

   always_comb begin
      adj = work_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (work_q[4*k +: 4] >= 4'd5) begin
            adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
         end
      end
      shifted = {adj, mag_q} << 1;
   end

   always_comb begin
      seen = 1'b0;
      mask = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         seen    = seen | (|work_q[4*k +: 4]);
         mask[k] = seen;
      end
      mask[0] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      mag_d   = mag_q;
      work_d  = work_q;
      sign_d  = sign_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      neg_d   = neg_q;
      dv_d    = dv_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cnv.start) begin
               sign_d  = cnv.is_signed & cnv.number_in[WIDTH-1];
               mag_d   = (cnv.is_signed && cnv.number_in[WIDTH-1]) ? neg_mag : cnv.number_in;
               work_d  = '0;
               cnt_d   = CW'(WIDTH);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            work_d = shifted[BW+WIDTH-1:WIDTH];
            mag_d  = shifted[WIDTH-1:0];
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            bcd_d   = work_q;
            neg_d   = sign_q & (|work_q);
            dv_d    = mask;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         mag_q   <= '0;
         work_q  <= '0;
         sign_q  <= 1'b0;
         cnt_q   <= '0;
         bcd_q   <= '0;
         neg_q   <= 1'b0;
         dv_q    <= DIGITS'(1);
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mag_q   <= mag_d;
         work_q  <= work_d;
         sign_q  <= sign_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         neg_q   <= neg_d;
         dv_q    <= dv_d;
         done_q  <= done_d;
      end
   end

   assign cnv.busy        = (state_q != IDLE);
   assign cnv.done        = done_q;
   assign cnv.bcd_out     = bcd_q;
   assign cnv.negative    = neg_q;
   assign cnv.digit_valid = dv_q;
endmodule

// File: tb/tb_bcd_converter_seq.sv
// tb/tb_bcd_converter_seq.sv - scoreboard bench for three converter widths (16/5, 8/3, 24/8)
module tb_bcd_converter_seq;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   typedef struct {
      int         idx;
      logic [39:0] bcd;
      logic        neg;
      logic [9:0]  dv;
   } exp_t;

   typedef struct {
      logic [31:0] v;
      bit          s;
      logic [19:0] bcd;
      logic        neg;
      logic [4:0]  dv;
   } vec_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   logic        start_v [3];
   logic [31:0] num_v   [3];
   logic        sgn_v   [3];
   logic        busy_v  [3];
   logic        done_v  [3];
   logic [39:0] bcd_v   [3];
   logic        neg_v   [3];
   logic [9:0]  dv_v    [3];

   bcd_converter_seq_if #(.WIDTH(16), .DIGITS(5)) if0 ();
   bcd_converter_seq_if #(.WIDTH(8),  .DIGITS(3)) if1 ();
   bcd_converter_seq_if #(.WIDTH(24), .DIGITS(8)) if2 ();

   bcd_converter_seq #(.WIDTH(16), .DIGITS(5)) u0 (.clk(clk), .reset(reset), .cnv(if0));
   bcd_converter_seq #(.WIDTH(8),  .DIGITS(3)) u1 (.clk(clk), .reset(reset), .cnv(if1));
   bcd_converter_seq #(.WIDTH(24), .DIGITS(8)) u2 (.clk(clk), .reset(reset), .cnv(if2));

   assign if0.start = start_v[0]; assign if0.number_in = num_v[0][15:0]; assign if0.is_signed = sgn_v[0];
   assign if1.start = start_v[1]; assign if1.number_in = num_v[1][7:0];  assign if1.is_signed = sgn_v[1];
   assign if2.start = start_v[2]; assign if2.number_in = num_v[2][23:0]; assign if2.is_signed = sgn_v[2];

   assign busy_v[0] = if0.busy; assign done_v[0] = if0.done; assign neg_v[0] = if0.negative;
   assign busy_v[1] = if1.busy; assign done_v[1] = if1.done; assign neg_v[1] = if1.negative;
   assign busy_v[2] = if2.busy; assign done_v[2] = if2.done; assign neg_v[2] = if2.negative;
   assign bcd_v[0] = {20'd0, if0.bcd_out}; assign dv_v[0] = {5'd0, if0.digit_valid};
   assign bcd_v[1] = {28'd0, if1.bcd_out}; assign dv_v[1] = {7'd0, if1.digit_valid};
   assign bcd_v[2] = {8'd0,  if2.bcd_out}; assign dv_v[2] = {2'd0, if2.digit_valid};

   function automatic int wid(input int idx);
      case (idx)
         0:       return 16;
         1:       return 8;
         default: return 24;
      endcase
   endfunction

   // Reference: decimal by repeated division, significance from the digit count.
   function automatic exp_t model(input int idx, input logic [31:0] v, input bit s);
      exp_t        e;
      int          w;
      logic [63:0] lim, m, t;
      int          nd;
      w   = wid(idx);
      lim = 64'd1 << w;
      m   = {32'd0, v} & (lim - 64'd1);
      e.idx = idx;
      e.neg = s && v[w-1];
      if (e.neg) m = (lim - m) & (lim - 64'd1);
      e.bcd = '0;
      t = m;
      for (int k = 0; k < 10; k++) begin
         e.bcd[4*k +: 4] = 4'(t % 64'd10);
         t = t / 64'd10;
      end
      nd = 1;
      t  = m / 64'd10;
      while (t != 0) begin
         nd++;
         t = t / 64'd10;
      end
      e.dv = 10'((64'd1 << nd) - 64'd1);
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic push(input int idx, input logic [39:0] b, input logic n, input logic [9:0] d);
      exp_t e;
      e.idx = idx; e.bcd = b; e.neg = n; e.dv = d;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         if (done_v[i]) begin
            if (exp_q.size() == 0 || exp_q[0].idx != i) begin
               check($sformatf("unexpected_done_%0d", i), 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("bcd_%0d", i), bcd_v[i], e.bcd);
               check($sformatf("negative_%0d", i), neg_v[i], e.neg);
               check($sformatf("digit_valid_%0d", i), dv_v[i], e.dv);
            end
         end
      end
   end

   task automatic check_reset_vals(input int idx);
      check($sformatf("rst_bcd_%0d", idx), bcd_v[idx], 0);
      check($sformatf("rst_neg_%0d", idx), neg_v[idx], 0);
      check($sformatf("rst_dv_%0d", idx), dv_v[idx], 1);
      check($sformatf("rst_busy_%0d", idx), busy_v[idx], 0);
      check($sformatf("rst_done_%0d", idx), done_v[idx], 0);
   endtask

   // Drives one request; inputs are scrambled right after the accepting edge.
   task automatic start_conv(input int idx, input logic [31:0] v, input bit s, input bit expect_it,
                             input logic [39:0] b, input logic n, input logic [9:0] d);
      @(negedge clk);
      start_v[idx] = 1'b1; num_v[idx] = v; sgn_v[idx] = s;
      @(posedge clk);
      if (expect_it) push(idx, b, n, d);
      #1;
      start_v[idx] = 1'b0; num_v[idx] = $urandom; sgn_v[idx] = 1'($urandom);
   endtask

   task automatic wait_done(input int idx);
      int n;
      bit got;
      got = 1'b0;
      for (n = 1; n <= 200; n++) begin
         @(posedge clk);
         #1;
         if (n == 1) check("busy_active", busy_v[idx], 1);
         if (done_v[idx]) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         check("done_timeout", 64'd0, 64'd1);
      end else begin
         check($sformatf("latency_%0d", idx), n, wid(idx) + 1);
         check("busy_in_done", busy_v[idx], 0);
      end
   endtask

   task automatic run(input int idx, input logic [31:0] v, input bit s,
                      input logic [39:0] b, input logic n, input logic [9:0] d);
      start_conv(idx, v, s, 1'b1, b, n, d);
      wait_done(idx);
   endtask

   vec_t vecs [12];
   exp_t e;
   logic [31:0] rv;

   initial begin
      vecs[0]  = '{32'hFFFF, 1'b0, 20'h65535, 1'b0, 5'b11111};
      vecs[1]  = '{32'h8000, 1'b1, 20'h32768, 1'b1, 5'b11111};
      vecs[2]  = '{32'hFFFF, 1'b1, 20'h00001, 1'b1, 5'b00001};
      vecs[3]  = '{32'h0000, 1'b0, 20'h00000, 1'b0, 5'b00001};
      vecs[4]  = '{32'h0000, 1'b1, 20'h00000, 1'b0, 5'b00001};
      vecs[5]  = '{32'h0064, 1'b1, 20'h00100, 1'b0, 5'b00111};
      vecs[6]  = '{32'h04D2, 1'b0, 20'h01234, 1'b0, 5'b01111};
      vecs[7]  = '{32'h7FFF, 1'b1, 20'h32767, 1'b0, 5'b11111};
      vecs[8]  = '{32'h8000, 1'b0, 20'h32768, 1'b0, 5'b11111};
      vecs[9]  = '{32'hFF9C, 1'b1, 20'h00100, 1'b1, 5'b00111};
      vecs[10] = '{32'h000A, 1'b0, 20'h00010, 1'b0, 5'b00011};
      vecs[11] = '{32'h0009, 1'b0, 20'h00009, 1'b0, 5'b00001};

      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0; num_v[i] = '0; sgn_v[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) check_reset_vals(i);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         run(0, vecs[i].v, vecs[i].s, {20'd0, vecs[i].bcd}, vecs[i].neg, {5'd0, vecs[i].dv});
      end

      // Results must hold while idle.
      repeat (5) @(posedge clk);
      #1;
      check("hold_bcd", bcd_v[0], {20'd0, vecs[11].bcd});
      check("hold_dv", dv_v[0], {5'd0, vecs[11].dv});

      // start held high while busy: only the done-cycle start is honoured.
      @(negedge clk);
      start_v[0] = 1'b1; num_v[0] = 32'd1234; sgn_v[0] = 1'b0;
      @(posedge clk);
      push(0, 40'h01234, 1'b0, 10'b0000001111);
      #1;
      num_v[0] = 32'd9999;
      wait_done(0);
      @(posedge clk);
      push(0, 40'h09999, 1'b0, 10'b0000001111);
      #1;
      start_v[0] = 1'b0;
      wait_done(0);

      // Reset mid-conversion aborts it silently.
      start_conv(0, 32'd4321, 1'b0, 1'b0, '0, 1'b0, '0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_reset_vals(0);
      @(negedge clk);
      reset = 1'b0;
      repeat (25) @(posedge clk);
      #1;
      check("post_abort_bcd", bcd_v[0], 0);
      run(0, 32'd77, 1'b0, 40'h00077, 1'b0, 10'b0000000011);

      // Width sweep against the reference model, including extremes.
      for (int idx = 1; idx < 3; idx++) begin
         for (int j = 0; j < 14; j++) begin
            case (j)
               0:       rv = 32'hFFFF_FFFF;
               1:       rv = 32'd1 << (wid(idx) - 1);
               2:       rv = 32'd0;
               default: rv = $urandom;
            endcase
            e = model(idx, rv, j[0]);
            run(idx, rv, j[0], e.bcd, e.neg, e.dv);
         end
      end

      repeat (3) @(posedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
